// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised 2-read / 1-write register file.
// One synchronous write port and two independent combinational read
// ports driving tri-state bitlines. Register 0 can be hardwired to zero,
// and a same-cycle write can optionally be forwarded to the readers.
// Neither port has a handshake: a read is requested by holding renN high
// and is answered in the same cycle; a write is requested by holding wen
// high and takes effect at the next rising clk edge.
module regfile_2r1w #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  ren1,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   inout  wire  [DATA_WIDTH-1:0] rdata1,
   input  logic                  ren2,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   inout  wire  [DATA_WIDTH-1:0] rdata2
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   logic                  write_ok;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;

   // A write to register 0 is dropped when it is hardwired to zero.
   always_comb begin
      write_ok = wen;
      if ((ZERO_REG != 0) && (waddr == '0)) begin
         write_ok = 1'b0;
      end
   end

   // Storage: asynchronous clear, then one write per rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (write_ok) begin
         mem[waddr] <= wdata;
      end
   end

   // Port 1 read value: reset, zero register, bypass, then stored word.
   always_comb begin
      rd1 = mem[raddr1];
      if (!rst) begin
         rd1 = '0;
      end else if ((ZERO_REG != 0) && (raddr1 == '0)) begin
         rd1 = '0;
      end else if ((BYPASS != 0) && wen && (raddr1 == waddr)) begin
         rd1 = wdata;
      end
   end

   // Port 2 read value: same priority as port 1, evaluated independently.
   always_comb begin
      rd2 = mem[raddr2];
      if (!rst) begin
         rd2 = '0;
      end else if ((ZERO_REG != 0) && (raddr2 == '0)) begin
         rd2 = '0;
      end else if ((BYPASS != 0) && wen && (raddr2 == waddr)) begin
         rd2 = wdata;
      end
   end

   // Bitlines are driven only while the port is enabled; otherwise released.
   assign rdata1 = ren1 ? rd1 : {DATA_WIDTH{1'bz}};
   assign rdata2 = ren2 ? rd2 : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench for regfile_2r1w.
// Two instances: the default build (16x16, zero register, bypass) and a
// wide build (32x32, no zero register, no bypass). Each shared bitline has
// a second bench-side driver that only drives while the DUT port is
// disabled, so a released bitline must show exactly that driver's value.
module tb_regfile_2r1w;

   localparam int DA = 16;
   localparam int AA = 4;
   localparam int DB = 32;
   localparam int AB = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A signals ----------------
   logic          wen_a = 0, ren1_a = 0, ren2_a = 0;
   logic [AA-1:0] waddr_a = 0, raddr1_a = 0, raddr2_a = 0;
   logic [DA-1:0] wdata_a = 0, probe1_a = 0, probe2_a = 0;
   wire  [DA-1:0] rdata1_a, rdata2_a;

   // ---------------- instance B signals ----------------
   logic          wen_b = 0, ren1_b = 0, ren2_b = 0;
   logic [AB-1:0] waddr_b = 0, raddr1_b = 0, raddr2_b = 0;
   logic [DB-1:0] wdata_b = 0, probe1_b = 0, probe2_b = 0;
   wire  [DB-1:0] rdata1_b, rdata2_b;

   // Other agents on the shared bitlines, active only while the port is off.
   assign rdata1_a = ren1_a ? {DA{1'bz}} : probe1_a;
   assign rdata2_a = ren2_a ? {DA{1'bz}} : probe2_a;
   assign rdata1_b = ren1_b ? {DB{1'bz}} : probe1_b;
   assign rdata2_b = ren2_b ? {DB{1'bz}} : probe2_b;

   regfile_2r1w #(.DATA_WIDTH(DA), .ADDR_WIDTH(AA), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
      .ren1(ren1_a), .raddr1(raddr1_a), .rdata1(rdata1_a),
      .ren2(ren2_a), .raddr2(raddr2_a), .rdata2(rdata2_a)
   );

   regfile_2r1w #(.DATA_WIDTH(DB), .ADDR_WIDTH(AB), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
      .ren1(ren1_b), .raddr1(raddr1_b), .rdata1(rdata1_b),
      .ren2(ren2_b), .raddr2(raddr2_b), .rdata2(rdata2_b)
   );

   // ---------------- behavioural model ----------------
   logic [DA-1:0] mdl_a [16];
   logic [DB-1:0] mdl_b [32];
   int n_vec = 0;
   int n_err = 0;

   initial begin
      foreach (mdl_a[i]) mdl_a[i] = '0;
      foreach (mdl_b[i]) mdl_b[i] = '0;
   end

   // Reset empties both files at once.
   always @(negedge rst) begin
      foreach (mdl_a[i]) mdl_a[i] = '0;
      foreach (mdl_b[i]) mdl_b[i] = '0;
   end

   // A clock edge out of reset commits the pending write (never into A's r0).
   always @(posedge clk) begin
      if (rst) begin
         if (wen_a && waddr_a != 0) mdl_a[waddr_a] = wdata_a;
         if (wen_b) mdl_b[waddr_b] = wdata_b;
      end
   end

   // What an enabled port of A must show right now.
   function automatic logic [DA-1:0] exp_a(input logic [AA-1:0] a);
      if (!rst) return '0;
      if (a == 0) return '0;
      if (wen_a && a == waddr_a) return wdata_a;
      return mdl_a[a];
   endfunction

   // What an enabled port of B must show right now (no forwarding).
   function automatic logic [DB-1:0] exp_b(input logic [AB-1:0] a);
      if (!rst) return '0;
      return mdl_b[a];
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Every cycle, mid-period: enabled ports match the model, released
   // bitlines carry only the other agent's value.
   always @(negedge clk) begin
      chk("cyc_a_rd1", {16'h0, rdata1_a}, ren1_a ? {16'h0, exp_a(raddr1_a)} : {16'h0, probe1_a});
      chk("cyc_a_rd2", {16'h0, rdata2_a}, ren2_a ? {16'h0, exp_a(raddr2_a)} : {16'h0, probe2_a});
      chk("cyc_b_rd1", rdata1_b, ren1_b ? exp_b(raddr1_b) : probe1_b);
      chk("cyc_b_rd2", rdata2_b, ren2_b ? exp_b(raddr2_b) : probe2_b);
   end

   // ---------------- driver tasks ----------------
   // Advance one clock; inputs are changed 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      probe1_a = DA'($urandom);
      probe2_a = DA'($urandom);
      probe1_b = $urandom;
      probe2_b = $urandom;
   endtask

   task automatic wr_a(input logic [AA-1:0] a, input logic [DA-1:0] d);
      wen_a = 1; waddr_a = a; wdata_a = d;
      cyc();
      wen_a = 0;
   endtask

   task automatic wr_b(input logic [AB-1:0] a, input logic [DB-1:0] d);
      wen_b = 1; waddr_b = a; wdata_b = d;
      cyc();
      wen_b = 0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // Held in reset: enabled ports read zero.
      ren1_a = 1; raddr1_a = 5;
      cyc();
      #1 chk("in_reset_a", {16'h0, rdata1_a}, 32'h0);
      rst = 1;
      cyc();

      // Asynchronous reset between edges.
      wr_a(5, 16'h1234);
      wr_b(5, 32'h0000_1234);
      ren1_a = 1; raddr1_a = 5; ren1_b = 1; raddr1_b = 5;
      #1 chk("pre_reset_a", {16'h0, rdata1_a}, 32'h1234);
      chk("pre_reset_b", rdata1_b, 32'h1234);
      rst = 0;
      #1 chk("async_reset_a", {16'h0, rdata1_a}, 32'h0);
      chk("async_reset_b", rdata1_b, 32'h0);
      // A write presented while reset spans the edge is discarded.
      wen_a = 1; waddr_a = 6; wdata_a = 16'hABCD;
      wen_b = 1; waddr_b = 6; wdata_b = 32'hABCD;
      cyc();
      wen_a = 0; wen_b = 0;
      rst = 1;
      ren2_a = 1; ren2_b = 1;
      for (int i = 0; i < 32; i++) begin
         raddr1_a = AA'(i); raddr2_a = AA'(i);
         raddr1_b = AB'(i); raddr2_b = AB'(i);
         #1;
         if (i < 16) begin
            chk("post_reset_a1", {16'h0, rdata1_a}, 32'h0);
            chk("post_reset_a2", {16'h0, rdata2_a}, 32'h0);
         end
         chk("post_reset_b1", rdata1_b, 32'h0);
         chk("post_reset_b2", rdata2_b, 32'h0);
      end

      // Write then read back, then swap addresses.
      wr_a(3, 16'hBEEF);
      wr_a(15, 16'h0F0F);
      raddr1_a = 3; raddr2_a = 15;
      #1 chk("wr_rd_a1", {16'h0, rdata1_a}, 32'hBEEF);
      chk("wr_rd_a2", {16'h0, rdata2_a}, 32'h0F0F);
      raddr1_a = 15; raddr2_a = 3;
      #1 chk("swap_a1", {16'h0, rdata1_a}, 32'h0F0F);
      chk("swap_a2", {16'h0, rdata2_a}, 32'hBEEF);
      cyc();

      // Zero register: A discards, B keeps.
      wen_a = 1; waddr_a = 0; wdata_a = 16'hFFFF; raddr1_a = 0;
      wen_b = 1; waddr_b = 0; wdata_b = 32'hFFFF; raddr1_b = 0;
      #1 chk("zero_same_cyc_a", {16'h0, rdata1_a}, 32'h0);
      chk("no_zero_same_cyc_b", rdata1_b, 32'h0);
      cyc();
      wen_a = 0; wen_b = 0;
      #1 chk("zero_next_a", {16'h0, rdata1_a}, 32'h0);
      chk("no_zero_next_b", rdata1_b, 32'hFFFF);
      cyc();
      #1 chk("zero_later_a", {16'h0, rdata1_a}, 32'h0);

      // Bypass on A, none on B.
      wr_a(7, 16'h1111);
      wr_b(7, 32'h1111);
      wen_a = 1; waddr_a = 7; wdata_a = 16'h2222; raddr1_a = 7; raddr2_a = 7;
      wen_b = 1; waddr_b = 7; wdata_b = 32'h2222; raddr1_b = 7; raddr2_b = 7;
      #1 chk("bypass_a1", {16'h0, rdata1_a}, 32'h2222);
      chk("bypass_a2", {16'h0, rdata2_a}, 32'h2222);
      chk("nobypass_b1", rdata1_b, 32'h1111);
      chk("nobypass_b2", rdata2_b, 32'h1111);
      cyc();
      wen_a = 0; wen_b = 0;
      #1 chk("after_edge_a1", {16'h0, rdata1_a}, 32'h2222);
      chk("after_edge_b1", rdata1_b, 32'h2222);
      chk("after_edge_b2", rdata2_b, 32'h2222);
      cyc();

      // Tri-state release and re-drive without a clock edge.
      ren1_a = 0; raddr1_a = 3; ren2_a = 1; raddr2_a = 3;
      #1 chk("released_a1", {16'h0, rdata1_a}, {16'h0, probe1_a});
      chk("driven_a2", {16'h0, rdata2_a}, 32'hBEEF);
      ren1_a = 1;
      #1 chk("redriven_a1", {16'h0, rdata1_a}, 32'hBEEF);
      ren2_a = 0; ren1_b = 0; ren2_b = 0;
      cyc();
      #1 chk("released_a2", {16'h0, rdata2_a}, {16'h0, probe2_a});
      chk("released_b1", rdata1_b, probe1_b);
      ren2_a = 1; ren1_b = 1; ren2_b = 1;

      // Wide build: top register and walking ones.
      wr_b(31, 32'hDEADBEEF);
      raddr1_b = 31; raddr2_b = 31;
      #1 chk("top_b1", rdata1_b, 32'hDEADBEEF);
      chk("top_b2", rdata2_b, 32'hDEADBEEF);
      for (int i = 0; i < 32; i++) wr_b(AB'(i), 32'h1 << i);
      for (int i = 1; i < 16; i++) wr_a(AA'(i), 16'h1 << i);
      for (int i = 0; i < 32; i++) begin
         raddr1_b = AB'(i); raddr2_b = AB'(31 - i);
         raddr1_a = AA'(i); raddr2_a = AA'(15 - (i % 16));
         #1;
         chk("walk_b1", rdata1_b, 32'h1 << i);
         chk("walk_b2", rdata2_b, 32'h1 << (31 - i));
         if (i < 16) chk("walk_a1", {16'h0, rdata1_a}, (i == 0) ? 32'h0 : (32'h1 << i));
      end
      cyc();

      // Mixed traffic, checked every cycle against the model.
      for (int i = 0; i < 200; i++) begin
         wen_a = 1'($urandom_range(0, 1));  waddr_a = AA'($urandom_range(0, 15));
         wdata_a = DA'($urandom);
         ren1_a = 1'($urandom_range(0, 1)); raddr1_a = ($urandom_range(0, 3) == 0) ? waddr_a : AA'($urandom_range(0, 15));
         ren2_a = 1'($urandom_range(0, 1)); raddr2_a = ($urandom_range(0, 3) == 0) ? waddr_a : AA'($urandom_range(0, 15));
         wen_b = 1'($urandom_range(0, 1));  waddr_b = AB'($urandom_range(0, 31));
         wdata_b = $urandom;
         ren1_b = 1'($urandom_range(0, 1)); raddr1_b = AB'($urandom_range(0, 31));
         ren2_b = 1'($urandom_range(0, 1)); raddr2_b = ($urandom_range(0, 3) == 0) ? waddr_b : AB'($urandom_range(0, 31));
         cyc();
      end
      wen_a = 0; wen_b = 0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
